rpn_stack_calc: RTL and testbench
=================================

# rpn_stack_calc

Parametrised reverse-Polish calculator controller with an internal operand stack and a built-in 4-function ALU. It generalises the fixed A/B/opcode sequence to a DEPTH-entry stack, and adds a one-level undo and overflow/underflow error handling. It sits between the debounced button pulse generators and the display mux. It exposes the top-of-stack and a display select.

## Interface
- WIDTH, 16, operand/result width in bits
- DEPTH, 4, stack entries; must be >= 2
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- enter_pulse  in  1  single-cycle push request
- op_pulse  in  1  single-cycle execute request
- undo_pulse  in  1  single-cycle undo request
- operand_in  in  WIDTH  value pushed on enter
- opcode_in  in  2  00 add, 01 sub, 10 and, 11 or
- top  out  WIDTH  stack[depth-1]; 0 when depth==0
- depth  out  $clog2(DEPTH+1)  current stack occupancy
- status  out  3  state code: IDLE 000, PUSH 001, EXEC 010, SHOW 011, UNDO 100, ERROR 111
- to_display_sel  out  1  1 = show operand_in, 0 = show top
- error  out  1  high while in ERROR
- push_strobe  out  1  high during PUSH
- exec_strobe  out  1  high during EXEC

## Operation
- Input pulses are sampled only in IDLE, SHOW and ERROR; pulses arriving in PUSH/EXEC/UNDO are dropped.
- Simultaneous pulses are resolved by priority: enter > op > undo.
- IDLE: enter -> PUSH; op -> EXEC if depth>=2, else ERROR; undo -> UNDO.
- PUSH (1 cycle): if depth==DEPTH -> ERROR, stack unchanged. Otherwise stack[depth] <= operand_in, depth++ -> IDLE.
- EXEC (1 cycle): operands are a=stack[depth-2] and b=stack[depth-1]. Writes stack[depth-2] <= f(a,b), depth-- -> SHOW.
- SHOW: to_display_sel=0. enter -> PUSH; op -> EXEC if depth>=2, else ERROR; undo -> UNDO.
- ERROR: error=1, to_display_sel=0. enter or undo -> IDLE with the stack untouched; op is ignored.
- UNDO (1 cycle): if the snapshot is valid, restore it and clear the valid flag, then -> IDLE. If the snapshot is not valid, go -> IDLE with no change.
- Snapshot contents: depth plus stack[depth-2..depth-1] as they were before the commit.
- Snapshot capture: taken on every successful PUSH and EXEC commit, which sets the valid flag.
- Arithmetic: modulo 2^WIDTH; sub computes a-b with wrap, and no carry is reported.
- Reset values: state IDLE, depth 0, all entries 0, snapshot invalid, top 0, status 000, to_display_sel 1, error/strobes 0.
- Reset asserted in any state overrides all pulses and takes effect on the next clock edge.

## Timing
- Registered state; all outputs are decoded from the current state and stack.
- Enter pulse seen at edge n: PUSH during cycle n+1; depth and top are updated and state is IDLE from edge n+2.
- Op pulse at edge n: EXEC during n+1; result on top and SHOW from n+2.
- Undo at edge n: UNDO during n+1; restored values visible from n+2.
- Back-to-back pulses on consecutive cycles: the second pulse is lost. The minimum accepted spacing is 2 cycles.

## Configuration
- RPN_UNDO_EN defined: UNDO state and snapshot registers are present, behaving as described above.
- RPN_UNDO_EN undefined: no snapshot storage and the UNDO state is absent. undo_pulse is ignored everywhere except ERROR, where it still returns to IDLE. Status code 100 never appears.

## Test plan
- Reset, push 5, push 3, op=00 -> status 011, top 8, depth 1.
- Push 2, push 7, op=01 (WIDTH 16) -> top 0xFFFB, depth 1.
- Push DEPTH values, then push once more -> status 111, error 1, depth DEPTH. Then enter -> IDLE, depth DEPTH.
- With depth 1, op -> ERROR; undo -> IDLE, depth 1, top unchanged.
- With RPN_UNDO_EN: push 4, push 6, op=10 -> top 4; undo -> depth 2, top 6; a second undo -> no change.
- Enter and op asserted together in IDLE -> PUSH taken and op dropped. Reset asserted during EXEC -> depth 0, status 000 next cycle.

Source files
------------

// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc: reverse-Polish calculator controller with a DEPTH-entry operand stack and 4-function ALU.
// Define RPN_UNDO_EN to build the one-level undo (UNDO state plus snapshot registers).
module rpn_stack_calc #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enter_pulse,
    input  logic                       op_pulse,
    input  logic                       undo_pulse,
    input  logic [WIDTH-1:0]           operand_in,
    input  logic [1:0]                 opcode_in,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic [2:0]                 status,
    output logic                       to_display_sel,
    output logic                       error,
    output logic                       push_strobe,
    output logic                       exec_strobe
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_PUSH  = 3'b001;
    localparam logic [2:0] ST_EXEC  = 3'b010;
    localparam logic [2:0] ST_SHOW  = 3'b011;
`ifdef RPN_UNDO_EN
    localparam logic [2:0] ST_UNDO  = 3'b100;
`endif
    localparam logic [2:0] ST_ERROR = 3'b111;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [DW-1:0]    depth_q;
    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [WIDTH-1:0] operand_q;
    logic [1:0]       opcode_q;

    logic             accepting;
    logic             stack_full;
    logic             can_exec;
    logic [IW-1:0]    idx_push;
    logic [IW-1:0]    idx_top;
    logic [IW-1:0]    idx_lo;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] alu_result;

    assign accepting  = (state_q == ST_IDLE) || (state_q == ST_SHOW);
    assign stack_full = (depth_q == DW'(DEPTH));
    assign can_exec   = (depth_q >= DW'(2));

    // Index arithmetic wraps in IW bits; only used when the depth makes it meaningful.
    assign idx_push = depth_q[IW-1:0];
    assign idx_top  = depth_q[IW-1:0] - IW'(1);
    assign idx_lo   = depth_q[IW-1:0] - IW'(2);

`ifdef RPN_UNDO_EN
    logic [DW-1:0]    snap_depth;
    logic [WIDTH-1:0] snap_hi;
    logic [WIDTH-1:0] snap_lo;
    logic             snap_valid;
    logic [IW-1:0]    snap_idx_top;
    logic [IW-1:0]    snap_idx_lo;

    assign snap_idx_top = snap_depth[IW-1:0] - IW'(1);
    assign snap_idx_lo  = snap_depth[IW-1:0] - IW'(2);

    // Snapshot of the two top entries and depth, taken just before each successful commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_depth <= '0;
            snap_hi    <= '0;
            snap_lo    <= '0;
            snap_valid <= 1'b0;
        end else if (((state_q == ST_PUSH) && !stack_full) || (state_q == ST_EXEC)) begin
            snap_depth <= depth_q;
            snap_hi    <= stack_mem[idx_top];
            snap_lo    <= stack_mem[idx_lo];
            snap_valid <= 1'b1;
        end else if (state_q == ST_UNDO) begin
            snap_valid <= 1'b0;
        end
    end
`endif

    always_comb begin
        opnd_a     = stack_mem[idx_lo];
        opnd_b     = stack_mem[idx_top];
        alu_result = '0;
        case (opcode_q)
            OP_ADD:  alu_result = opnd_a + opnd_b;
            OP_SUB:  alu_result = opnd_a - opnd_b;
            OP_AND:  alu_result = opnd_a & opnd_b;
            OP_OR:   alu_result = opnd_a | opnd_b;
            default: alu_result = '0;
        endcase
    end

    // Priority enter > op > undo; pulses are only looked at in IDLE, SHOW and ERROR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (enter_pulse) begin
                    state_d = ST_PUSH;
                end else if (op_pulse) begin
                    state_d = can_exec ? ST_EXEC : ST_ERROR;
                end
`ifdef RPN_UNDO_EN
                else if (undo_pulse) begin
                    state_d = ST_UNDO;
                end
`endif
            end
            ST_PUSH:  state_d = stack_full ? ST_ERROR : ST_IDLE;
            ST_EXEC:  state_d = ST_SHOW;
            ST_ERROR: begin
                if (enter_pulse || undo_pulse) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operand and opcode are captured alongside the pulse so the commit cycle uses them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            depth_q   <= '0;
            operand_q <= '0;
            opcode_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accepting) begin
                operand_q <= operand_in;
                opcode_q  <= opcode_in;
            end
            case (state_q)
                ST_PUSH: begin
                    if (!stack_full) begin
                        stack_mem[idx_push] <= operand_q;
                        depth_q             <= depth_q + DW'(1);
                    end
                end
                ST_EXEC: begin
                    stack_mem[idx_lo] <= alu_result;
                    depth_q           <= depth_q - DW'(1);
                end
`ifdef RPN_UNDO_EN
                ST_UNDO: begin
                    if (snap_valid) begin
                        depth_q <= snap_depth;
                        if (snap_depth >= DW'(1)) begin
                            stack_mem[snap_idx_top] <= snap_hi;
                        end
                        if (snap_depth >= DW'(2)) begin
                            stack_mem[snap_idx_lo] <= snap_lo;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign depth          = depth_q;
    assign top            = (depth_q == '0) ? '0 : stack_mem[idx_top];
    assign status         = state_q;
    assign to_display_sel = !((state_q == ST_SHOW) || (state_q == ST_ERROR));
    assign error          = (state_q == ST_ERROR);
    assign push_strobe    = (state_q == ST_PUSH);
    assign exec_strobe    = (state_q == ST_EXEC);

endmodule

// File: tb/tb_rpn_stack_calc.sv
// tb_rpn_stack_calc: directed and randomized checks of rpn_stack_calc against a queue-based stack model.
// Undo expectations follow RPN_UNDO_EN, matching the build of the design.
module tb_rpn_stack_calc;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PUSH  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_SHOW  = 3'd3;
    localparam logic [2:0] S_UNDO  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd7;

    logic             clk = 1'b0;
    logic             reset;
    logic             enter_pulse;
    logic             op_pulse;
    logic             undo_pulse;
    logic [WIDTH-1:0] operand_in;
    logic [1:0]       opcode_in;
    logic [WIDTH-1:0] top;
    logic [2:0]       depth;
    logic [2:0]       status;
    logic             to_display_sel;
    logic             error;
    logic             push_strobe;
    logic             exec_strobe;

    int vecCount  = 0;
    int missCount = 0;

    logic [WIDTH-1:0] mStack[$];
    logic [WIDTH-1:0] mSnap[$];
    bit               mSnapValid;
    logic [2:0]       mState;

    rpn_stack_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .enter_pulse    (enter_pulse),
        .op_pulse       (op_pulse),
        .undo_pulse     (undo_pulse),
        .operand_in     (operand_in),
        .opcode_in      (opcode_in),
        .top            (top),
        .depth          (depth),
        .status         (status),
        .to_display_sel (to_display_sel),
        .error          (error),
        .push_strobe    (push_strobe),
        .exec_strobe    (exec_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] modelTop();
        if (mStack.size() == 0) return '0;
        return mStack[$];
    endfunction

    function automatic logic [WIDTH-1:0] aluRef(input logic [1:0] opc, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (opc)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic bit selFor(input logic [2:0] st);
        return !((st == S_SHOW) || (st == S_ERROR));
    endfunction

    task automatic checkSettled(input string tag);
        checkOutput({tag, "_status"}, 32'(status), 32'(mState));
        checkOutput({tag, "_depth"}, 32'(depth), 32'(mStack.size()));
        checkOutput({tag, "_top"}, 32'(top), 32'(modelTop()));
        checkOutput({tag, "_error"}, 32'(error), 32'(mState == S_ERROR));
        checkOutput({tag, "_sel"}, 32'(to_display_sel), 32'(selFor(mState)));
    endtask

    task automatic modelReset();
        mStack.delete();
        mSnap.delete();
        mSnapValid = 1'b0;
        mState     = S_IDLE;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset       = 1'b1;
        enter_pulse = 1'b0;
        op_pulse    = 1'b0;
        undo_pulse  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkSettled("reset");
        checkOutput("reset_push_strobe", 32'(push_strobe), 32'd0);
        checkOutput("reset_exec_strobe", 32'(exec_strobe), 32'd0);
    endtask

    // One request: pulse for a cycle, check the transient state, then the settled result.
    task automatic applyStimulus(input bit en, input bit op, input bit un, input logic [WIDTH-1:0] val,
                                 input logic [1:0] opc, input bit lateEnter, input bit lateOp,
                                 input string tag);
        logic [2:0]       midState;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        midState = mState;
        if (mState == S_ERROR) begin
            if (en || un) begin
                midState = S_IDLE;
                mState   = S_IDLE;
            end
        end else if (en) begin
            midState = S_PUSH;
            if (mStack.size() == DEPTH) begin
                mState = S_ERROR;
            end else begin
                mSnap      = mStack;
                mSnapValid = 1'b1;
                mStack.push_back(val);
                mState = S_IDLE;
            end
        end else if (op) begin
            if (mStack.size() >= 2) begin
                midState   = S_EXEC;
                mSnap      = mStack;
                mSnapValid = 1'b1;
                b = mStack.pop_back();
                a = mStack.pop_back();
                mStack.push_back(aluRef(opc, a, b));
                mState = S_SHOW;
            end else begin
                midState = S_ERROR;
                mState   = S_ERROR;
            end
        end else if (un) begin
`ifdef RPN_UNDO_EN
            midState = S_UNDO;
            if (mSnapValid) begin
                mStack     = mSnap;
                mSnapValid = 1'b0;
            end
            mState = S_IDLE;
`endif
        end

        @(negedge clk);
        enter_pulse = en;
        op_pulse    = op;
        undo_pulse  = un;
        operand_in  = val;
        opcode_in   = opc;
        @(negedge clk);
        enter_pulse = 1'b0;
        op_pulse    = 1'b0;
        undo_pulse  = 1'b0;
        if ((midState == S_PUSH) || (midState == S_EXEC) || (midState == S_UNDO)) begin
            enter_pulse = lateEnter;
            op_pulse    = lateOp;
        end
        checkOutput({tag, "_mid_status"}, 32'(status), 32'(midState));
        checkOutput({tag, "_mid_push"}, 32'(push_strobe), 32'(midState == S_PUSH));
        checkOutput({tag, "_mid_exec"}, 32'(exec_strobe), 32'(midState == S_EXEC));
        checkOutput({tag, "_mid_sel"}, 32'(to_display_sel), 32'(selFor(midState)));
        @(negedge clk);
        enter_pulse = 1'b0;
        op_pulse    = 1'b0;
        checkSettled(tag);
    endtask

    task automatic push(input logic [WIDTH-1:0] val);
        applyStimulus(1'b1, 1'b0, 1'b0, val, 2'd0, 1'b0, 1'b0, "push");
    endtask

    initial begin
        int r;
        reset       = 1'b1;
        enter_pulse = 1'b0;
        op_pulse    = 1'b0;
        undo_pulse  = 1'b0;
        operand_in  = '0;
        opcode_in   = '0;

        doReset();
        push(16'd5);
        push(16'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 2'b00, 1'b0, 1'b0, "add");
        checkOutput("plan_add_status", 32'(status), 32'd3);
        checkOutput("plan_add_top", 32'(top), 32'd8);
        checkOutput("plan_add_depth", 32'(depth), 32'd1);

        doReset();
        push(16'd2);
        push(16'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 2'b01, 1'b1, 1'b0, "sub");
        checkOutput("plan_sub_top", 32'(top), 32'hFFFB);
        checkOutput("plan_sub_depth", 32'(depth), 32'd1);

        doReset();
        for (int i = 0; i < DEPTH; i++) push(WIDTH'(i + 10));
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 2'd0, 1'b0, 1'b1, "overflow");
        checkOutput("plan_ovf_status", 32'(status), 32'd7);
        checkOutput("plan_ovf_error", 32'(error), 32'd1);
        checkOutput("plan_ovf_depth", 32'(depth), 32'(DEPTH));
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h5555, 2'd0, 1'b0, 1'b0, "ovf_clear");
        checkOutput("plan_ovf_clr_status", 32'(status), 32'd0);
        checkOutput("plan_ovf_clr_depth", 32'(depth), 32'(DEPTH));

        doReset();
        push(16'd9);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0, "underflow");
        checkOutput("plan_unf_status", 32'(status), 32'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0, "err_op_ignored");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, 2'd0, 1'b0, 1'b0, "unf_undo");
        checkOutput("plan_unf_undo_status", 32'(status), 32'd0);
        checkOutput("plan_unf_undo_depth", 32'(depth), 32'd1);
        checkOutput("plan_unf_undo_top", 32'(top), 32'd9);

`ifdef RPN_UNDO_EN
        doReset();
        push(16'd4);
        push(16'd6);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 2'b10, 1'b0, 1'b0, "and");
        checkOutput("plan_and_top", 32'(top), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, 2'd0, 1'b1, 1'b0, "undo1");
        checkOutput("plan_undo1_depth", 32'(depth), 32'd2);
        checkOutput("plan_undo1_top", 32'(top), 32'd6);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, 2'd0, 1'b0, 1'b0, "undo2");
        checkOutput("plan_undo2_depth", 32'(depth), 32'd2);
        checkOutput("plan_undo2_top", 32'(top), 32'd6);
`else
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, 2'd0, 1'b0, 1'b0, "undo_ignored");
        checkOutput("plan_undo_off_status", 32'(status), 32'd0);
`endif

        doReset();
        push(16'd1);
        push(16'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hBEEF, 2'd0, 1'b0, 1'b0, "enter_op");
        checkOutput("plan_prio_depth", 32'(depth), 32'd3);
        checkOutput("plan_prio_top", 32'(top), 32'hBEEF);

        // Reset asserted while EXEC is in flight.
        @(negedge clk);
        op_pulse  = 1'b1;
        opcode_in = 2'b00;
        @(negedge clk);
        op_pulse = 1'b0;
        checkOutput("rst_exec_mid_status", 32'(status), 32'(S_EXEC));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_exec_status", 32'(status), 32'd0);
        checkOutput("rst_exec_depth", 32'(depth), 32'd0);
        checkOutput("rst_exec_top", 32'(top), 32'd0);
        reset = 1'b0;
        modelReset();

        for (int n = 0; n < 400; n++) begin
            if ((n % 100) == 0) doReset();
            r = $urandom_range(0, 99);
            applyStimulus(r < 40 || (r >= 90 && r < 95),
                          (r >= 40 && r < 70) || (r >= 90 && r < 95),
                          (r >= 70 && r < 90),
                          WIDTH'($urandom),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
